// File: rtl/cpu_user_interface.sv
// cpu_user_interface: button debounce, CPU start/step sequencing and 8-digit seven-segment scan
module cpu_user_interface #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn_start,
  input  logic        i_btn_step,
  input  logic        i_sw_step,
  input  logic [1:0]  i_sw_sel,
  input  logic        i_instr_transmit_done,
  input  logic [7:0]  i_max_addr,
  input  logic        i_halt,
  input  logic [15:0] i_alu_result,
  input  logic [15:0] i_alu_P,
  input  logic [15:0] i_alu_Q,
  input  logic [2:0]  i_alu_op,
  input  logic [4:0]  i_flags,
  output logic        o_start_cpu,
  output logic        o_step_execution,
  output logic        o_next_instr_stimulus,
  output logic [1:0]  o_state,
  output logic [7:0]  o_an,
  output logic [7:0]  o_seg
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = SCAN_CYCLES > 1 ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOADED = 2'd1;
  localparam logic [1:0] RUN = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;
  localparam logic [15:0][6:0] HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0] stable_q, stable_d, prev_q, prev_d, press;
  logic [1:0] state_q, state_d;
  logic start_q, start_d, stim_q, stim_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [2:0] digit_q, digit_d;
  logic [7:0] an_q, an_d, seg_q, seg_d;
  logic [31:0] page;
  logic [3:0] nibble;
  always_comb begin
    sync1_d = {i_sw_sel, i_sw_step, i_btn_step, i_btn_start};
    sync2_d = sync1_q;
    cnt_d = cnt_q;
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (sync2_q[i] == stable_q[i] || cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[i] + DW'(1);
      stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? sync2_q[i] : stable_q[i];
    end
    prev_d = stable_q;
    press = stable_q & ~prev_q;
    state_d = state_q == IDLE   ? (i_instr_transmit_done ? LOADED : IDLE) :
              state_q == LOADED ? (press[0] ? RUN : LOADED) :
              state_q == RUN    ? (i_halt ? HALTED : RUN) : HALTED;
    start_d = state_q == RUN || state_q == HALTED;
    stim_d = press[1] && sync2_q[2] && state_q == RUN;
    scan_d = scan_q == SW'(SCAN_CYCLES - 1) ? '0 : scan_q + SW'(1);
    digit_d = scan_q == SW'(SCAN_CYCLES - 1) ? digit_q + 3'd1 : digit_q;
    page = sync2_q[4:3] == 2'd0 ? {i_alu_P, i_alu_result} :
           sync2_q[4:3] == 2'd1 ? {i_alu_Q, i_alu_result} :
           {i_max_addr, 4'h0, 1'b0, i_alu_op, 4'h0, 3'b000, i_flags[4], i_flags[3:0], 2'b00, state_q};
    nibble = page[{digit_q, 2'b00} +: 4];
    an_d = ~(8'd1 << digit_q);
    seg_d = {~(i_halt && digit_q == 3'd0), sync2_q[4:3] == 2'd3 ? 7'h3F : HEX[nibble]};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q <= '0;
      stable_q <= '0;
      prev_q <= '0;
      state_q <= IDLE;
      start_q <= 1'b0;
      stim_q <= 1'b0;
      scan_q <= '0;
      digit_q <= '0;
      an_q <= 8'hFF;
      seg_q <= 8'hFF;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q <= cnt_d;
      stable_q <= stable_d;
      prev_q <= prev_d;
      state_q <= state_d;
      start_q <= start_d;
      stim_q <= stim_d;
      scan_q <= scan_d;
      digit_q <= digit_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  assign o_start_cpu = start_q;
  assign o_step_execution = sync2_q[2];
  assign o_next_instr_stimulus = stim_q;
  assign o_state = state_q;
  assign o_an = an_q;
  assign o_seg = seg_q;
endmodule

// File: tb/tb_cpu_user_interface.sv
// tb_cpu_user_interface: directed self-checking bench for cpu_user_interface
module tb_cpu_user_interface;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0, btn_step = 1'b0, sw_step = 1'b0;
  logic [1:0] sw_sel = 2'd0;
  logic done = 1'b0, halt = 1'b0;
  logic [7:0] max_addr = 8'h00;
  logic [15:0] alu_result = 16'h0, alu_p = 16'h0, alu_q = 16'h0;
  logic [2:0] alu_op = 3'd0;
  logic [4:0] flags = 5'd0;
  logic start_cpu, step_exec, stim;
  logic [1:0] state;
  logic [7:0] an, seg;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cpu_user_interface #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_start(btn_start), .i_btn_step(btn_step),
    .i_sw_step(sw_step), .i_sw_sel(sw_sel), .i_instr_transmit_done(done),
    .i_max_addr(max_addr), .i_halt(halt), .i_alu_result(alu_result),
    .i_alu_P(alu_p), .i_alu_Q(alu_q), .i_alu_op(alu_op), .i_flags(flags),
    .o_start_cpu(start_cpu), .o_step_execution(step_exec),
    .o_next_instr_stimulus(stim), .o_state(state), .o_an(an), .o_seg(seg)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction
  task automatic test_reset;
    sw_step = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an cyc%0d got %h want FF", k, an); end
      checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg cyc%0d got %h want FF", k, seg); end
      checks++; if (start_cpu !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL reset_fsm cyc%0d got start=%b state=%0d want 0/0", k, start_cpu, state); end
      checks++; if (step_exec !== 1'b0 || stim !== 1'b0) begin errors++; $display("FAIL reset_step cyc%0d got exec=%b stim=%b want 0/0", k, step_exec, stim); end
    end
    rst = 1'b0;
    checks++; if (an !== 8'hFF || seg !== 8'hFF) begin errors++; $display("FAIL reset_release_disp got an=%h seg=%h want FF/FF", an, seg); end
    tick();
    checks++; if (start_cpu !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL reset_after got start=%b state=%0d want 0/0", start_cpu, state); end
    checks++; if (step_exec !== 1'b0) begin errors++; $display("FAIL sync_latency1 got %b want 0", step_exec); end
    tick();
    checks++; if (step_exec !== 1'b1) begin errors++; $display("FAIL sync_latency2 got %b want 1", step_exec); end
    sw_step = 1'b0;
    tick(3);
  endtask
  task automatic test_start;
    int rises;
    logic prev_start, seen_run, start_at_run;
    logic bad;
    bad = 1'b0;
    btn_start = 1'b1;
    for (int k = 0; k < 12; k++) begin tick(); if (state !== 2'd0) bad = 1'b1; end
    btn_start = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); if (state !== 2'd0) bad = 1'b1; end
    checks++; if (bad) begin errors++; $display("FAIL idle_press got state=%0d want 0", state); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL loaded got state=%0d want 1", state); end
    checks++; if (start_cpu !== 1'b0) begin errors++; $display("FAIL loaded_start got %b want 0", start_cpu); end
    btn_start = 1'b1;
    rises = 0; prev_start = start_cpu; seen_run = 1'b0; start_at_run = 1'bx;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (start_cpu === 1'b1 && prev_start !== 1'b1) rises++;
      prev_start = start_cpu;
      if (state === 2'd2 && !seen_run) begin seen_run = 1'b1; start_at_run = start_cpu; end
    end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL run got state=%0d want 2", state); end
    checks++; if (rises !== 1) begin errors++; $display("FAIL start_rises got %0d want 1", rises); end
    checks++; if (start_at_run !== 1'b0) begin errors++; $display("FAIL start_lag got %b want 0", start_at_run); end
    btn_start = 1'b0;
    tick(10);
  endtask
  task automatic test_step_pulse;
    int pulses;
    sw_step = 1'b1;
    tick(3);
    checks++; if (step_exec !== 1'b1) begin errors++; $display("FAIL step_exec_on got %b want 1", step_exec); end
    pulses = 0;
    btn_step = 1'b1; tick(); if (stim === 1'b1) pulses++;
    btn_step = 1'b0; tick(); if (stim === 1'b1) pulses++;
    btn_step = 1'b1;
    for (int k = 0; k < 20; k++) begin tick(); if (stim === 1'b1) pulses++; end
    btn_step = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); if (stim === 1'b1) pulses++; end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL step_pulses got %0d want 1", pulses); end
  endtask
  task automatic test_step_mode_off;
    int pulses;
    sw_step = 1'b0;
    tick(3);
    checks++; if (step_exec !== 1'b0) begin errors++; $display("FAIL step_exec_off got %b want 0", step_exec); end
    pulses = 0;
    btn_step = 1'b1;
    for (int k = 0; k < 20; k++) begin tick(); if (stim === 1'b1) pulses++; end
    btn_step = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); if (stim === 1'b1) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL step_off_pulses got %0d want 0", pulses); end
  endtask
  task automatic test_page(input logic [1:0] sel, input logic [31:0] word, input logic dash, input logic dp0);
    int n, idx;
    logic [7:0] exp_an, exp_seg;
    sw_sel = sel;
    tick(4);
    n = 0;
    while (an !== 8'hFE && n < 20) begin tick(); n++; end
    for (int k = 0; k < 9; k++) begin
      idx = k % 8;
      exp_an = ~(8'd1 << idx);
      if (k > 0) begin
        n = 0;
        while (an !== exp_an && n < 4) begin tick(); n++; end
        checks++; if (n !== 2) begin errors++; $display("FAIL page%0d_dwell digit%0d got %0d want 2", sel, idx, n); end
      end
      checks++; if (an !== exp_an) begin errors++; $display("FAIL page%0d_an digit%0d got %h want %h", sel, idx, an, exp_an); end
      exp_seg = {~(dp0 && idx == 0), dash ? 7'h3F : hex7(word[idx*4 +: 4])};
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL page%0d_seg digit%0d got %h want %h", sel, idx, seg, exp_seg); end
    end
  endtask
  task automatic test_halt;
    halt = 1'b1;
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL halted got state=%0d want 3", state); end
    checks++; if (start_cpu !== 1'b1) begin errors++; $display("FAIL halted_start got %b want 1", start_cpu); end
    halt = 1'b0;
    btn_start = 1'b1;
    tick(10);
    btn_start = 1'b0;
    tick(10);
    checks++; if (state !== 2'd3 || start_cpu !== 1'b1) begin errors++; $display("FAIL halted_sticky got state=%0d start=%b want 3/1", state, start_cpu); end
    halt = 1'b1;
  endtask
  task automatic test_reset_mid;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (state !== 2'd0 || start_cpu !== 1'b0) begin errors++; $display("FAIL mid_reset_fsm got state=%0d start=%b want 0/0", state, start_cpu); end
    checks++; if (an !== 8'hFF || seg !== 8'hFF) begin errors++; $display("FAIL mid_reset_disp got an=%h seg=%h want FF/FF", an, seg); end
    tick(3);
  endtask
  task automatic test_halt_with_start;
    int n;
    halt = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL prio_loaded got state=%0d want 1", state); end
    btn_start = 1'b1;
    n = 0;
    while (state === 2'd1 && n < 15) begin tick(); n++; end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL prio_run got state=%0d want 2", state); end
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL prio_halt got state=%0d want 3", state); end
    btn_start = 1'b0;
    halt = 1'b0;
    tick(2);
  endtask
  initial begin
    test_reset();
    test_start();
    test_step_pulse();
    test_step_mode_off();
    alu_p = 16'h1234; alu_q = 16'h5A6B; alu_result = 16'hABCD;
    test_page(2'd0, 32'h1234ABCD, 1'b0, 1'b0);
    test_page(2'd1, 32'h5A6BABCD, 1'b0, 1'b0);
    max_addr = 8'h3F; alu_op = 3'd5; flags = 5'h12;
    test_page(2'd2, 32'h3F050122, 1'b0, 1'b0);
    test_halt();
    test_page(2'd3, 32'h0, 1'b1, 1'b1);
    test_reset_mid();
    test_halt_with_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
